opb_register_bank_ppc2simulink: RTL and testbench

Parametrised OPB slave holding a bank of `N_REGS` 32-bit software registers in a single clock domain. It is the multi-register successor of the single ppc2simulink register. Each register is configured by `DIR_MASK` as either PPC-writable (drives fabric) or fabric-writable (PPC read-only snapshot). Writes support byte enables, and the block emits per-register update/read strobes so user logic sees exactly when software touched a register. It sits on the ROACH XPS OPB bus beside the other Simulink-facing software registers.

---
 rtl/opb_register_bank_ppc2simulink.sv | 97 +++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: OPB slave bank of software registers with byte-enable writes and access strobes
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]       C_BASEADDR = 32'h01003100,
  parameter logic [31:0]       C_HIGHADDR = 32'h010031FF,
  parameter int                N_REGS     = 4,
  parameter logic [N_REGS-1:0] DIR_MASK   = {N_REGS{1'b1}},
  parameter logic [31:0]       REG_INIT   = 32'h0
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst_n,
  input  logic [0:31]          OPB_ABus,
  input  logic [0:3]           OPB_BE,
  input  logic [0:31]          OPB_DBus,
  input  logic                 OPB_RNW,
  input  logic                 OPB_select,
  input  logic                 OPB_seqAddr,
  output logic [0:31]          Sl_DBus,
  output logic                 Sl_xferAck,
  output logic                 Sl_errAck,
  output logic                 Sl_retry,
  output logic                 Sl_toutSup,
  output logic [32*N_REGS-1:0] user_data_out,
  input  logic [32*N_REGS-1:0] user_data_in,
  output logic [N_REGS-1:0]    user_wr_strobe,
  output logic [N_REGS-1:0]    user_rd_strobe
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nx;
  logic [31:0] addr, off, wd_q, rd_q, sel_rd, be_mask;
  logic [29:0] idx_q;
  logic [3:0] be_q;
  logic rnw_q, hit;
  logic [N_REGS-1:0] acc;
  logic unused_bits;
  assign addr = OPB_ABus;
  assign off = addr - C_BASEADDR;
  assign hit = OPB_select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
  assign unused_bits = ^{OPB_seqAddr, off[1:0], user_data_in};
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  // state register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) state <= IDLE;
    else state <= state_nx;
  // a hit starts a transfer; the ack lasts exactly one cycle
  always_comb state_nx = (state == IDLE && hit) ? ACK : IDLE;
  // ack, OR-bus read data and read strobes
  always_comb begin
    Sl_xferAck = state == ACK;
    Sl_DBus = (state == ACK && rnw_q) ? rd_q : '0;
    user_rd_strobe = rnw_q ? acc : '0;
  end
  // one-hot of the register addressed by the current ack (zero outside ACK)
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_REGS; i++) acc[i] = state == ACK && idx_q == 30'(i);
  end
  // read value chosen at the hit edge; contents cannot change before the ack
  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < N_REGS; i++)
      if (off[31:2] == 30'(i)) sel_rd = DIR_MASK[i] ? user_data_out[32*i +: 32] : user_data_in[32*i +: 32];
  end
  // latch the transfer attributes when a hit is accepted
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) begin
      idx_q <= '0;
      rnw_q <= 1'b0;
      be_q <= '0;
      wd_q <= '0;
      rd_q <= '0;
    end else if (state == IDLE && hit) begin
      idx_q <= off[31:2];
      rnw_q <= OPB_RNW;
      be_q <= OPB_BE;
      wd_q <= OPB_DBus;
      rd_q <= sel_rd;
    end
  // write strobe follows the edge that commits the write, even for BE=0000
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) user_wr_strobe <= '0;
    else user_wr_strobe <= rnw_q ? '0 : acc & DIR_MASK;
  for (genvar r = 0; r < N_REGS; r++) begin : g_reg
    if (DIR_MASK[r]) begin : g_rw
      logic [31:0] q;
      // byte-enabled update at the edge ending ACK
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
        if (!OPB_Rst_n) q <= REG_INIT;
        else if (acc[r] && !rnw_q) q <= (q & ~be_mask) | (wd_q & be_mask);
      assign user_data_out[32*r +: 32] = q;
    end else begin : g_ro
      assign user_data_out[32*r +: 32] = '0;
    end
  end
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb_opb_register_bank_ppc2simulink: directed bench with a transfer-level model checked every cycle
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01003100;
  localparam logic [31:0] HIGH = 32'h010031FF;
  localparam logic [31:0] INIT = 32'hA5A50000;
  localparam logic [3:0] DIR = 4'b1011;
  logic clk = 0, rst_n = 0, rnw = 0, sel = 0, seq = 0;
  logic [0:31] abus = 0, dbus = 0, sl_dbus;
  logic [0:3] be = 0;
  logic ack, err, rty, tout;
  logic [127:0] udo, udi = 0;
  logic [3:0] wr, rd;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .N_REGS(4), .DIR_MASK(DIR), .REG_INIT(INIT)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus), .Sl_xferAck(ack),
    .Sl_errAck(err), .Sl_retry(rty), .Sl_toutSup(tout), .user_data_out(udo),
    .user_data_in(udi), .user_wr_strobe(wr), .user_rd_strobe(rd)
  );
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask
  // transfer-level model: registers as an array, pending ack as a flag
  logic [31:0] m_reg [4];
  bit m_ack, m_rnw;
  int m_idx;
  logic [0:3] m_be;
  logic [31:0] m_wd, m_rd;
  logic [3:0] m_wstb;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [0:3] b);
    merge = o;
    for (int k = 0; k < 4; k++) if (b[k]) merge[31-8*k -: 8] = n[31-8*k -: 8];
  endfunction
  function automatic int word(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  function automatic logic [31:0] rd_val(input int w);
    if (w >= 4) return 32'h0;
    return DIR[w] ? m_reg[w] : udi[32*w +: 32];
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] <= DIR[i] ? INIT : 32'h0;
      m_ack <= 0;
      m_rnw <= 0;
      m_idx <= 0;
      m_rd <= 0;
      m_wstb <= 0;
    end else if (m_ack) begin
      m_ack <= 0;
      m_wstb <= 0;
      if (!m_rnw && m_idx < 4 && DIR[m_idx]) begin
        m_reg[m_idx] <= merge(m_reg[m_idx], m_wd, m_be);
        m_wstb <= 4'(1 << m_idx);
      end
    end else begin
      m_wstb <= 0;
      if (sel && abus >= BASE && abus <= HIGH) begin
        m_ack <= 1;
        m_rnw <= rnw;
        m_idx <= word(abus);
        m_be <= be;
        m_wd <= dbus;
        m_rd <= rd_val(word(abus));
      end
    end
  always @(negedge clk) begin
    chk("ack", ack, m_ack);
    chk("dbus", sl_dbus, (m_ack && m_rnw) ? m_rd : 32'h0);
    chk("rd_stb", rd, (m_ack && m_rnw && m_idx < 4) ? 4'(1 << m_idx) : 4'h0);
    chk("wr_stb", wr, m_wstb);
    chk("udo", udo, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    chk("const", {err, rty, tout}, 0);
  end
  task automatic xfer(input logic [31:0] a, input logic r, input logic [0:3] b, input logic [31:0] d,
                      output logic a1, output logic [31:0] d1, output logic [3:0] r1, output logic [3:0] w2);
    abus = a; rnw = r; be = b; dbus = d; sel = 1;
    @(negedge clk);
    a1 = ack; d1 = sl_dbus; r1 = rd; sel = 0;
    @(negedge clk);
    w2 = wr;
  endtask
  initial begin
    logic a1;
    logic [31:0] d1;
    logic [3:0] r1, w2;
    repeat (2) @(negedge clk);
    chk("reset_out", udo, {INIT, 32'h0, INIT, INIT});
    chk("reset_ack", ack, 0);
    rst_n = 1;
    @(negedge clk);
    xfer(BASE + 4, 0, 4'b1111, 32'h12345678, a1, d1, r1, w2);
    chk("wr1_ack", a1, 1);
    chk("wr1_out", udo[63:32], 32'h12345678);
    chk("wr1_stb", w2, 4'b0010);
    xfer(BASE + 4, 1, 4'b1111, 32'h0, a1, d1, r1, w2);
    chk("rd1_data", d1, 32'h12345678);
    chk("rd1_stb", r1, 4'b0010);
    xfer(BASE, 0, 4'b1111, 32'h12345678, a1, d1, r1, w2);
    xfer(BASE, 0, 4'b0100, 32'hFFFFFFFF, a1, d1, r1, w2);
    chk("be_out", udo[31:0], 32'h12FF5678);
    xfer(BASE + 4, 0, 4'b0000, 32'hFFFFFFFF, a1, d1, r1, w2);
    chk("touch_stb", w2, 4'b0010);
    chk("touch_out", udo[63:32], 32'h12345678);
    udi[95:64] = 32'hDEADBEEF;
    xfer(BASE + 8, 1, 4'b1111, 32'h0, a1, d1, r1, w2);
    chk("ro_rd", d1, 32'hDEADBEEF);
    chk("ro_rd_stb", r1, 4'b0100);
    chk("ro_dbus_after", sl_dbus, 0);
    xfer(BASE + 8, 0, 4'b1111, 32'h11111111, a1, d1, r1, w2);
    chk("ro_wr_ack", a1, 1);
    chk("ro_wr_stb", w2, 0);
    chk("ro_out", udo[95:64], 0);
    xfer(BASE + 32'h40, 1, 4'b1111, 32'h0, a1, d1, r1, w2);
    chk("unmap_rd_ack", a1, 1);
    chk("unmap_rd_data", d1, 0);
    chk("unmap_rd_stb", r1, 0);
    xfer(BASE + 32'h40, 0, 4'b1111, 32'hCAFEF00D, a1, d1, r1, w2);
    chk("unmap_wr_ack", a1, 1);
    chk("unmap_wr_stb", w2, 0);
    xfer(HIGH + 4, 1, 4'b1111, 32'h0, a1, d1, r1, w2);
    chk("oor_ack1", a1, 0);
    chk("oor_ack2", ack, 0);
    abus = BASE; rnw = 1; be = 4'b1111; sel = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("burst_c%0d", c), ack, c % 2);
      if (c == 1) chk("burst_data", sl_dbus, 32'h12FF5678);
    end
    sel = 0;
    @(negedge clk);
    sel = 1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_ack", ack, 1);
    rst_n = 0;
    #1;
    chk("rst_drop", ack, 0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_ack", ack, 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ack", ack, 1);
    sel = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_out", udo, {INIT, 32'h0, INIT, INIT});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
